bwd_skid_buf: RTL and testbench

Parametrised backward-ready pipeline buffer with `DEPTH` entries and an optional zero-latency bypass. It breaks the combinational `ready` path between a slave and its master while sustaining full throughput. It sits on any valid/ready datapath where a single-entry backward stage does not absorb enough downstream stall, such as NoC ports and DMA read-return paths. Data order is strictly preserved.

---
 rtl/bwd_skid_buf_if.sv | 22 ++
 rtl/bwd_skid_buf.sv | 78 +++++++
 tb/tb_bwd_skid_buf.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/bwd_skid_buf_if.sv
// Valid/ready handshake bundle for bwd_skid_buf: master side (f_*) and slave side (b_*).
// The buffer connects through the slave modport; the environment uses the master modport.
interface bwd_skid_buf_if #(
  parameter int unsigned DATA_W = 256
);
  logic              f_valid_in;
  logic [DATA_W-1:0] f_data_in;
  logic              f_ready_out;
  logic              b_valid_out;
  logic [DATA_W-1:0] b_data_out;
  logic              b_ready_in;

  modport master (
    output f_valid_in, f_data_in, b_ready_in,
    input  f_ready_out, b_valid_out, b_data_out
  );

  modport slave (
    input  f_valid_in, f_data_in, b_ready_in,
    output f_ready_out, b_valid_out, b_data_out
  );
endinterface

// File: rtl/bwd_skid_buf.sv
// DEPTH-entry backward-ready buffer with optional zero-latency bypass.
// f_ready_out depends only on stored state and flush, never on b_ready_in.
module bwd_skid_buf #(
  parameter int unsigned DATA_W = 256,
  parameter int unsigned DEPTH  = 4,
  parameter bit          BYPASS = 1'b1,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  bwd_skid_buf_if.slave    bus,
  input  logic             flush,
  output logic [CNT_W-1:0] count
);

  localparam int unsigned      PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] FULL  = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] LAST  = PTR_W'(DEPTH - 1);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              empty, f_ready, f_acc, bypass, push, pop;

  // Handshake decode
  assign empty   = (count_q == '0);
  assign f_ready = ~flush & (count_q != FULL);
  assign f_acc   = bus.f_valid_in & f_ready;
  assign bypass  = BYPASS & empty & bus.b_ready_in & f_acc;
  assign push    = f_acc & ~bypass;
  assign pop     = ~flush & ~empty & bus.b_ready_in;

  assign bus.f_ready_out = f_ready;
  assign bus.b_valid_out = ~flush & (~empty | (BYPASS & f_acc));
  assign bus.b_data_out  = ~empty ? mem_q[rd_ptr_q]
                         : (BYPASS ? bus.f_data_in : '0);
  assign count           = count_q;

  // Next state; flush overrides any push/pop in the same cycle
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = (wr_ptr_q == LAST) ? '0 : wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = (rd_ptr_q == LAST) ? '0 : rd_ptr_q + PTR_W'(1);
      if (push && !pop)      count_d = count_q + CNT_W'(1);
      else if (pop && !push) count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (push) begin
      mem_q[wr_ptr_q] <= bus.f_data_in;
    end
  end

endmodule

// File: tb/tb_bwd_skid_buf.sv
// Directed scoreboard bench for bwd_skid_buf: three configurations (bypass/depth 4,
// registered/depth 2, bypass/depth 3) with per-instance expected-beat queues.
module tb_bwd_skid_buf;

  localparam int unsigned DW = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       flush_a, flush_b, flush_c;
  logic [2:0] cnt_a;
  logic [1:0] cnt_b, cnt_c;

  int n_vec = 0;
  int n_err = 0;

  logic [DW-1:0] q_a [$];
  logic [DW-1:0] q_b [$];
  logic [DW-1:0] q_c [$];

  always #5 clk = ~clk;

  bwd_skid_buf_if #(.DATA_W(DW)) if_a ();
  bwd_skid_buf_if #(.DATA_W(DW)) if_b ();
  bwd_skid_buf_if #(.DATA_W(DW)) if_c ();

  bwd_skid_buf #(.DATA_W(DW), .DEPTH(4), .BYPASS(1'b1)) u_a (
    .clk(clk), .rst_n(rst_n), .bus(if_a), .flush(flush_a), .count(cnt_a));
  bwd_skid_buf #(.DATA_W(DW), .DEPTH(2), .BYPASS(1'b0)) u_b (
    .clk(clk), .rst_n(rst_n), .bus(if_b), .flush(flush_b), .count(cnt_b));
  bwd_skid_buf #(.DATA_W(DW), .DEPTH(3), .BYPASS(1'b1)) u_c (
    .clk(clk), .rst_n(rst_n), .bus(if_c), .flush(flush_c), .count(cnt_c));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitors: a beat transfers when valid & ready at the next rising edge
  always @(negedge clk) begin
    if (rst_n === 1'b1 && if_a.b_valid_out && if_a.b_ready_in) begin
      if (q_a.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL a_unexpected_beat: got 0x%0h want none", if_a.b_data_out);
      end else chk("a_data", 32'(if_a.b_data_out), 32'(q_a.pop_front()));
    end
    if (rst_n === 1'b1 && if_b.b_valid_out && if_b.b_ready_in) begin
      if (q_b.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL b_unexpected_beat: got 0x%0h want none", if_b.b_data_out);
      end else chk("b_data", 32'(if_b.b_data_out), 32'(q_b.pop_front()));
    end
    if (rst_n === 1'b1 && if_c.b_valid_out && if_c.b_ready_in) begin
      if (q_c.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL c_unexpected_beat: got 0x%0h want none", if_c.b_data_out);
      end else chk("c_data", 32'(if_c.b_data_out), 32'(q_c.pop_front()));
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1, "timeout");
  end

  initial begin
    int k;
    rst_n   = 1'b0;
    flush_a = 1'b0; flush_b = 1'b0; flush_c = 1'b0;
    if_a.f_valid_in = 1'b1; if_a.f_data_in = 8'h3C; if_a.b_ready_in = 1'b0;
    if_b.f_valid_in = 1'b1; if_b.f_data_in = 8'h3C; if_b.b_ready_in = 1'b0;
    if_c.f_valid_in = 1'b0; if_c.f_data_in = 8'h00; if_c.b_ready_in = 1'b0;

    // Reset state
    cyc();
    chk("rst_a_count", 32'(cnt_a), 0);
    chk("rst_a_ready", 32'(if_a.f_ready_out), 1);
    chk("rst_a_valid", 32'(if_a.b_valid_out), 1);
    chk("rst_a_data", 32'(if_a.b_data_out), 32'h3C);
    chk("rst_b_valid", 32'(if_b.b_valid_out), 0);
    chk("rst_b_data", 32'(if_b.b_data_out), 0);
    chk("rst_b_ready", 32'(if_b.f_ready_out), 1);
    @(negedge clk);
    #2 rst_n = 1'b1;
    if_a.f_valid_in = 1'b0; if_b.f_valid_in = 1'b0;

    // A: bypass streaming 0x01..0x10 with the slave always ready
    if_a.b_ready_in = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      cyc();
      if_a.f_valid_in = 1'b1;
      if_a.f_data_in  = 8'(i);
      chk("a_bp_ready", 32'(if_a.f_ready_out), 1);
      q_a.push_back(8'(i));
      @(negedge clk);
      chk("a_bp_count", 32'(cnt_a), 0);
      chk("a_bp_valid", 32'(if_a.b_valid_out), 1);
    end
    cyc();
    if_a.f_valid_in = 1'b0;

    // A: fill to full with the slave stalled
    if_a.b_ready_in = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cyc();
      if_a.f_valid_in = 1'b1;
      if_a.f_data_in  = 8'(8'hA0 + i);
      chk("a_fill_ready", 32'(if_a.f_ready_out), 1);
      q_a.push_back(8'(8'hA0 + i));
      @(negedge clk);
      chk("a_fill_valid", 32'(if_a.b_valid_out), 1);
    end
    cyc();
    if_a.f_data_in = 8'hA4;
    chk("a_full_count", 32'(cnt_a), 4);
    chk("a_full_ready", 32'(if_a.f_ready_out), 0);
    cyc();
    chk("a_hold_ready", 32'(if_a.f_ready_out), 0);
    @(negedge clk);
    chk("a_hold_head", 32'(if_a.b_data_out), 32'hA0);
    // Full with simultaneous accept: pop only
    cyc();
    if_a.b_ready_in = 1'b1;
    chk("a_fullpop_ready", 32'(if_a.f_ready_out), 0);
    cyc();
    chk("a_fullpop_count", 32'(cnt_a), 3);
    chk("a_refill_ready", 32'(if_a.f_ready_out), 1);
    q_a.push_back(8'hA4);
    cyc();
    if_a.f_data_in = 8'hA5;
    chk("a_a5_ready", 32'(if_a.f_ready_out), 1);
    q_a.push_back(8'hA5);
    cyc();
    if_a.f_valid_in = 1'b0;
    for (int w = 0; w < 20 && cnt_a != 0; w++) cyc();
    chk("a_drain_count", 32'(cnt_a), 0);
    chk("a_drain_queue", 32'(q_a.size()), 0);

    // A: flush with three stored beats
    if_a.b_ready_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      if_a.f_valid_in = 1'b1;
      if_a.f_data_in  = 8'(8'h10 + i);
    end
    cyc();
    chk("a_preflush_count", 32'(cnt_a), 3);
    flush_a = 1'b1;
    if_a.f_data_in = 8'h77;
    #1;
    chk("a_flush_ready", 32'(if_a.f_ready_out), 0);
    chk("a_flush_valid", 32'(if_a.b_valid_out), 0);
    cyc();
    flush_a = 1'b0;
    if_a.f_valid_in = 1'b0;
    chk("a_postflush_count", 32'(cnt_a), 0);
    if_a.b_ready_in = 1'b1;
    @(negedge clk);
    chk("a_postflush_valid", 32'(if_a.b_valid_out), 0);

    // A: asynchronous reset in the middle of a stall
    if_a.b_ready_in = 1'b0;
    for (int i = 0; i < 2; i++) begin
      cyc();
      if_a.f_valid_in = 1'b1;
      if_a.f_data_in  = 8'(8'h20 + i);
    end
    cyc();
    if_a.f_valid_in = 1'b0;
    chk("a_prerst_count", 32'(cnt_a), 2);
    #2 rst_n = 1'b0;
    #1;
    chk("a_arst_count", 32'(cnt_a), 0);
    chk("a_arst_ready", 32'(if_a.f_ready_out), 1);
    chk("a_arst_valid", 32'(if_a.b_valid_out), 0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    if_a.b_ready_in = 1'b1;
    cyc();
    @(negedge clk);
    chk("a_nostale_valid", 32'(if_a.b_valid_out), 0);
    if_a.b_ready_in = 1'b0;

    // B: registered mode, 1-cycle latency
    if_b.b_ready_in = 1'b1;
    cyc();
    if_b.f_valid_in = 1'b1;
    if_b.f_data_in  = 8'h55;
    chk("b_c0_ready", 32'(if_b.f_ready_out), 1);
    q_b.push_back(8'h55);
    @(negedge clk);
    chk("b_c0_valid", 32'(if_b.b_valid_out), 0);
    cyc();
    if_b.f_valid_in = 1'b0;
    @(negedge clk);
    chk("b_c1_valid", 32'(if_b.b_valid_out), 1);
    chk("b_c1_count", 32'(cnt_b), 1);
    cyc();
    chk("b_c2_count", 32'(cnt_b), 0);
    @(negedge clk);
    chk("b_c2_valid", 32'(if_b.b_valid_out), 0);
    // B: full throughput with simultaneous push and pop
    for (int i = 0; i < 6; i++) begin
      cyc();
      if_b.f_valid_in = 1'b1;
      if_b.f_data_in  = 8'(8'h60 + i);
      chk("b_stream_ready", 32'(if_b.f_ready_out), 1);
      chk("b_stream_count", 32'(cnt_b), (i == 0) ? 0 : 1);
      q_b.push_back(8'(8'h60 + i));
    end
    cyc();
    if_b.f_valid_in = 1'b0;
    chk("b_tail_count", 32'(cnt_b), 1);
    cyc();
    chk("b_empty_count", 32'(cnt_b), 0);
    chk("b_drain_queue", 32'(q_b.size()), 0);

    // C: pointer wrap, DEPTH=3, slave stalls 2 of every 4 cycles
    k = 0;
    for (int t = 0; t < 200 && k < 20; t++) begin
      logic acc;
      cyc();
      if_c.b_ready_in = ((t % 4) >= 2);
      if_c.f_valid_in = 1'b1;
      if_c.f_data_in  = 8'(8'hC0 + k);
      acc = if_c.f_ready_out;
      if (acc) q_c.push_back(8'(8'hC0 + k));
      @(negedge clk);
      if (cnt_c > 2'd3 || cnt_c === 2'bxx) chk("c_count_max", 32'(cnt_c), 3);
      if (acc) k++;
    end
    cyc();
    if_c.f_valid_in = 1'b0;
    if_c.b_ready_in = 1'b1;
    for (int w = 0; w < 20 && q_c.size() != 0; w++) cyc();
    chk("c_sent_beats", 32'(k), 20);
    chk("c_drain_queue", 32'(q_c.size()), 0);
    chk("c_drain_count", 32'(cnt_c), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
